// File: rtl/stack_pkg.sv
// Shared definitions for the bit-stack register and its command sequencer.
package stack_pkg;

    // Stack modes, shared bit-for-bit with the downstream stack register
    typedef enum logic [2:0] {
        MODE_IDLE  = 3'b000,
        MODE_PUSH  = 3'b001,
        MODE_POP   = 3'b010,
        MODE_SWAP  = 3'b011,
        MODE_RESET = 3'b111
    } stack_mode_e;

    // Sequencer opcodes
    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_PUSHN = 3'b001,
        OP_POPN  = 3'b010,
        OP_SWAP  = 3'b011,
        OP_DUP   = 3'b100,
        OP_NOT   = 3'b101,
        OP_BINOP = 3'b110,
        OP_CLEAR = 3'b111
    } cmd_op_e;

    // BINOP function select (cmd_data[1:0])
    typedef enum logic [1:0] {
        FN_AND  = 2'b00,
        FN_OR   = 2'b01,
        FN_XOR  = 2'b10,
        FN_NAND = 2'b11
    } binop_fn_e;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        S_INIT = 2'b00,
        S_IDLE = 2'b01,
        S_EXEC = 2'b10
    } seq_state_e;

    // Evaluate the BINOP function on the two top-of-stack bits
    function automatic logic binop_eval(input logic [1:0] fn, input logic a, input logic b);
        logic r;
        r = 1'b0;
        case (fn)
            FN_AND:  r = a & b;
            FN_OR:   r = a | b;
            FN_XOR:  r = a ^ b;
            FN_NAND: r = ~(a & b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/stack_step_rom.sv
// Combinational step table: (op, data, step index, latched q) -> (mode, push bit, last step).
module stack_step_rom
    import stack_pkg::*;
(
    input  logic [2:0] op,
    input  logic [3:0] data,
    input  logic [1:0] idx,
    input  logic [1:0] q,
    output logic [2:0] mode,
    output logic       d,
    output logic       last
);

    // Decode one step of the selected command; d is 0 unless the step is a PUSH
    always_comb begin
        mode = MODE_IDLE;
        d    = 1'b0;
        last = 1'b1;
        case (op)
            OP_PUSHN: begin
                mode = MODE_PUSH;
                d    = data[2'd3 - idx];
                last = (idx == 2'd3);
            end
            OP_POPN: begin
                mode = MODE_POP;
                last = (idx == data[1:0]);
            end
            OP_SWAP: begin
                mode = MODE_SWAP;
            end
            OP_DUP: begin
                mode = MODE_PUSH;
                d    = q[0];
            end
            OP_NOT: begin
                if (idx == 2'd0) begin
                    mode = MODE_POP;
                    last = 1'b0;
                end else begin
                    mode = MODE_PUSH;
                    d    = ~q[0];
                end
            end
            OP_BINOP: begin
                if (idx != 2'd2) begin
                    mode = MODE_POP;
                    last = 1'b0;
                end else begin
                    mode = MODE_PUSH;
                    d    = binop_eval(data[1:0], q[0], q[1]);
                end
            end
            OP_CLEAR: begin
                mode = MODE_RESET;
            end
            default: begin
                mode = MODE_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/stack_cmd_sequencer.sv
// Command sequencer for the bit-stack register: expands one command into
// consecutive stack steps and tracks stack depth and overflow/underflow.
module stack_cmd_sequencer
    import stack_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [2:0]                   cmd_op,
    input  logic [3:0]                   cmd_data,
    input  logic [1:0]                   stack_q,
    output logic [2:0]                   stack_mode,
    output logic                         stack_d,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         err
);

    localparam int             DW        = $clog2(DEPTH + 1);
    localparam logic [DW-1:0]  DEPTH_MAX = DW'(DEPTH);

    seq_state_e  state;
    logic [2:0]  op_r;
    logic [3:0]  data_r;
    logic [1:0]  q_r;
    logic [1:0]  idx;
    logic        last_r;

    logic [2:0]  rom_op;
    logic [3:0]  rom_data;
    logic [1:0]  rom_idx;
    logic [1:0]  rom_q;
    logic [2:0]  rom_mode;
    logic        rom_d;
    logic        rom_last;

    assign cmd_ready = (state == S_IDLE);

    // The ROM looks up step 0 from the live command while idle so the first
    // step is registered at the accept edge; during EXEC it looks up the next step.
    always_comb begin
        rom_op   = cmd_op;
        rom_data = cmd_data;
        rom_q    = stack_q;
        rom_idx  = 2'd0;
        if (state == S_EXEC) begin
            rom_op   = op_r;
            rom_data = data_r;
            rom_q    = q_r;
            rom_idx  = idx + 2'd1;
        end
    end

    stack_step_rom u_rom (
        .op   (rom_op),
        .data (rom_data),
        .idx  (rom_idx),
        .q    (rom_q),
        .mode (rom_mode),
        .d    (rom_d),
        .last (rom_last)
    );

    // Sequencer FSM with registered stack mode, push bit and busy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_INIT;
            stack_mode <= MODE_RESET;
            stack_d    <= 1'b0;
            busy       <= 1'b0;
            op_r       <= '0;
            data_r     <= '0;
            q_r        <= '0;
            idx        <= '0;
            last_r     <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    state      <= S_IDLE;
                    stack_mode <= MODE_IDLE;
                    stack_d    <= 1'b0;
                end
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_r   <= cmd_op;
                        data_r <= cmd_data;
                        q_r    <= stack_q;
                        if (cmd_op != OP_NOP) begin
                            state      <= S_EXEC;
                            busy       <= 1'b1;
                            stack_mode <= rom_mode;
                            stack_d    <= rom_d;
                            last_r     <= rom_last;
                            idx        <= '0;
                        end
                    end
                end
                S_EXEC: begin
                    if (last_r) begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        stack_mode <= MODE_IDLE;
                        stack_d    <= 1'b0;
                    end else begin
                        idx        <= idx + 2'd1;
                        stack_mode <= rom_mode;
                        stack_d    <= rom_d;
                        last_r     <= rom_last;
                    end
                end
                default: begin
                    state      <= S_INIT;
                    stack_mode <= MODE_RESET;
                    stack_d    <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Depth and error tracking, updated on the edge where the stack applies the mode on the port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            depth <= '0;
            err   <= 1'b0;
        end else begin
            case (stack_mode)
                MODE_PUSH: begin
                    if (depth == DEPTH_MAX) err <= 1'b1;
                    else                    depth <= depth + DW'(1);
                end
                MODE_POP: begin
                    if (depth == '0) err <= 1'b1;
                    else             depth <= depth - DW'(1);
                end
                MODE_SWAP: begin
                    if (depth < DW'(2)) err <= 1'b1;
                end
                MODE_RESET: begin
                    depth <= '0;
                    err   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// Directed testbench for stack_cmd_sequencer with hand-computed expectations.
module tb_stack_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [1:0] stack_q;
    logic [2:0] stack_mode;
    logic       stack_d;
    logic       busy;
    logic [3:0] depth;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    stack_cmd_sequencer #(.DEPTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .stack_q    (stack_q),
        .stack_mode (stack_mode),
        .stack_d    (stack_d),
        .busy       (busy),
        .depth      (depth),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [3:0] data);
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        int j;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 4'd0;
        stack_q   = 2'b00;
        tick();
        tick();

        // reset state
        check("rst_mode",  8'(stack_mode), 8'd7);
        check("rst_busy",  8'(busy),       8'd0);
        check("rst_depth", 8'(depth),      8'd0);
        check("rst_err",   8'(err),        8'd0);
        check("rst_ready", 8'(cmd_ready),  8'd0);

        // INIT cycle after release, then IDLE
        rst_n = 1'b1;
        check("init_mode",  8'(stack_mode), 8'd7);
        check("init_ready", 8'(cmd_ready),  8'd0);
        tick();
        check("idle_mode",  8'(stack_mode), 8'd0);
        check("idle_ready", 8'(cmd_ready),  8'd1);

        // PUSHN 1011 -> d = 1,0,1,1
        pat = 4'b1011;
        do_cmd(3'd1, pat);
        for (int i = 0; i < 4; i++) begin
            check("pushn_mode",  8'(stack_mode), 8'd1);
            check("pushn_d",     8'(stack_d),    8'(pat[3-i]));
            check("pushn_busy",  8'(busy),       8'd1);
            check("pushn_ready", 8'(cmd_ready),  8'd0);
            check("pushn_depth", 8'(depth),      8'(i));
            tick();
        end
        check("pushn_done_ready", 8'(cmd_ready),  8'd1);
        check("pushn_done_busy",  8'(busy),       8'd0);
        check("pushn_done_mode",  8'(stack_mode), 8'd0);
        check("pushn_done_depth", 8'(depth),      8'd4);

        // BINOP XOR with q=01 latched; live q changes afterwards
        stack_q = 2'b01;
        do_cmd(3'd6, 4'b1110);
        stack_q = 2'b10;
        check("xor_m0", 8'(stack_mode), 8'd2);
        check("xor_d0", 8'(stack_d),    8'd0);
        tick();
        check("xor_m1", 8'(stack_mode), 8'd2);
        check("xor_dp1", 8'(depth),     8'd3);
        tick();
        check("xor_m2", 8'(stack_mode), 8'd1);
        check("xor_d2", 8'(stack_d),    8'd1);
        check("xor_dp2", 8'(depth),     8'd2);
        tick();
        check("xor_done_mode",  8'(stack_mode), 8'd0);
        check("xor_done_depth", 8'(depth),      8'd3);
        check("xor_done_err",   8'(err),        8'd0);

        // reset during step 2 of PUSHN
        do_cmd(3'd1, 4'b0000);
        tick();
        check("mid_step2", 8'(stack_mode), 8'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_mode",  8'(stack_mode), 8'd7);
        check("mid_rst_busy",  8'(busy),       8'd0);
        check("mid_rst_depth", 8'(depth),      8'd0);
        check("mid_rst_err",   8'(err),        8'd0);
        rst_n = 1'b1;
        check("mid_init_ready", 8'(cmd_ready),  8'd0);
        check("mid_init_mode",  8'(stack_mode), 8'd7);
        tick();
        check("mid_idle_ready", 8'(cmd_ready),  8'd1);
        check("mid_idle_mode",  8'(stack_mode), 8'd0);

        // underflow: POPN data=01 from empty
        do_cmd(3'd2, 4'b0001);
        check("uf_m0",  8'(stack_mode), 8'd2);
        check("uf_dp0", 8'(depth),      8'd0);
        tick();
        check("uf_m1",  8'(stack_mode), 8'd2);
        check("uf_err1", 8'(err),       8'd1);
        tick();
        check("uf_done_mode",  8'(stack_mode), 8'd0);
        check("uf_done_depth", 8'(depth),      8'd0);
        check("uf_done_err",   8'(err),        8'd1);

        // CLEAR
        do_cmd(3'd7, 4'b0000);
        check("clr_mode", 8'(stack_mode), 8'd7);
        check("clr_busy", 8'(busy),       8'd1);
        check("clr_err0", 8'(err),        8'd1);
        tick();
        check("clr_done_mode", 8'(stack_mode), 8'd0);
        check("clr_done_err",  8'(err),        8'd0);

        // overflow: three PUSHN, 12 PUSH cycles
        j = 0;
        for (int c = 0; c < 3; c++) begin
            do_cmd(3'd1, 4'b1111);
            for (int s = 0; s < 4; s++) begin
                check("ovf_mode",  8'(stack_mode), 8'd1);
                check("ovf_depth", 8'(depth),      (j > 8) ? 8'd8 : 8'(j));
                check("ovf_err",   8'(err),        (j >= 9) ? 8'd1 : 8'd0);
                j++;
                tick();
            end
            check("ovf_ready", 8'(cmd_ready), 8'd1);
        end
        check("ovf_final_depth", 8'(depth), 8'd8);
        check("ovf_final_err",   8'(err),   8'd1);

        // handshake: SWAP held during POPN x4
        cmd_op    = 3'd2;
        cmd_data  = 4'b0011;
        cmd_valid = 1'b1;
        tick();
        cmd_op   = 3'd3;
        cmd_data = 4'b0000;
        for (int s = 0; s < 4; s++) begin
            check("hs_mode",  8'(stack_mode), 8'd2);
            check("hs_ready", 8'(cmd_ready),  8'd0);
            check("hs_depth", 8'(depth),      8'(8 - s));
            tick();
        end
        check("hs_idle_ready", 8'(cmd_ready),  8'd1);
        check("hs_idle_mode",  8'(stack_mode), 8'd0);
        check("hs_idle_depth", 8'(depth),      8'd4);
        tick();
        cmd_valid = 1'b0;
        check("hs_swap_mode", 8'(stack_mode), 8'd3);
        check("hs_swap_busy", 8'(busy),       8'd1);
        tick();
        check("hs_after_mode",  8'(stack_mode), 8'd0);
        check("hs_after_depth", 8'(depth),      8'd4);
        check("hs_after_err",   8'(err),        8'd1);

        // NOP: accepted, no step
        do_cmd(3'd0, 4'b1111);
        check("nop_mode",  8'(stack_mode), 8'd0);
        check("nop_ready", 8'(cmd_ready),  8'd1);
        check("nop_busy",  8'(busy),       8'd0);
        tick();
        check("nop_mode2", 8'(stack_mode), 8'd0);

        // DUP with q0=1
        stack_q = 2'b11;
        do_cmd(3'd4, 4'b0000);
        stack_q = 2'b00;
        check("dup_mode", 8'(stack_mode), 8'd1);
        check("dup_d",    8'(stack_d),    8'd1);
        tick();
        check("dup_depth", 8'(depth), 8'd5);

        // NOT with q0=1 -> POP, PUSH 0; then NOT with q0=0 -> PUSH 1
        stack_q = 2'b01;
        do_cmd(3'd5, 4'b0000);
        check("not_m0", 8'(stack_mode), 8'd2);
        tick();
        check("not_m1", 8'(stack_mode), 8'd1);
        check("not_d1", 8'(stack_d),    8'd0);
        tick();
        stack_q = 2'b10;
        do_cmd(3'd5, 4'b0000);
        tick();
        check("not2_d1", 8'(stack_d), 8'd1);
        tick();
        check("not2_depth", 8'(depth), 8'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
